// File: rtl/note_lane_shifter_if.sv
// rtl/note_lane_shifter_if.sv - sequencer-to-lane handshake and lane status bundle
interface note_lane_shifter_if #(
  parameter int WIDTH     = 16,
  parameter int DIV_WIDTH = 8
);
  logic                 load_n;
  logic [WIDTH-1:0]     load_val;
  logic                 serial_in;
  logic                 shift_en;
  logic                 dir;
  logic [DIV_WIDTH-1:0] rate;
  logic                 hit;
  logic [WIDTH-1:0]     out;
  logic                 serial_out;
  logic                 step;
  logic                 hit_ok;
  logic                 miss;

  modport master (
    output load_n, load_val, serial_in, shift_en, dir, rate, hit,
    input  out, serial_out, step, hit_ok, miss
  );

  modport slave (
    input  load_n, load_val, serial_in, shift_en, dir, rate, hit,
    output out, serial_out, step, hit_ok, miss
  );
endinterface

// File: rtl/note_lane_shifter.sv
// rtl/note_lane_shifter.sv - note scrolling lane with rate divider, hit window and miss detect
module note_lane_shifter #(
  parameter int WIDTH     = 16,
  parameter int DIV_WIDTH = 8,
  parameter int HIT_POS   = 1
) (
  input logic              clk,
  input logic              rst,
  note_lane_shifter_if.slave bus
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     lane_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 serial_out_q;
  logic                 step_q;
  logic                 hit_ok_q;
  logic                 miss_q;

  logic                 term;
  logic                 hit_found;
  logic [WIDTH-1:0]     lane_v;
  logic [WIDTH-1:0]     lane_sh;
  logic                 exit_bit;

  // A hit consumes the note before the step, so a note struck on its exit edge never counts as a miss.
  always_comb begin
    term      = bus.shift_en && (div_cnt >= bus.rate);
    hit_found = bus.hit && lane_q[HIT_POS];
    lane_v    = lane_q;
    if (bus.hit) begin
      lane_v[HIT_POS] = 1'b0;
    end
    if (bus.dir) begin
      lane_sh  = {lane_v[WIDTH-2:0], bus.serial_in};
      exit_bit = lane_v[WIDTH-1];
    end else begin
      lane_sh  = {bus.serial_in, lane_v[WIDTH-1:1]};
      exit_bit = lane_v[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q       <= '0;
      div_cnt      <= '0;
      serial_out_q <= 1'b0;
      step_q       <= 1'b0;
      hit_ok_q     <= 1'b0;
      miss_q       <= 1'b0;
    end else if (!bus.load_n) begin
      lane_q   <= bus.load_val;
      div_cnt  <= '0;
      step_q   <= 1'b0;
      hit_ok_q <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      hit_ok_q <= hit_found;
      if (bus.shift_en) begin
        div_cnt <= term ? '0 : div_cnt + DIV_ONE;
      end
      if (term) begin
        lane_q       <= lane_sh;
        serial_out_q <= exit_bit;
        miss_q       <= exit_bit;
        step_q       <= 1'b1;
      end else begin
        lane_q <= lane_v;
        step_q <= 1'b0;
        miss_q <= 1'b0;
      end
    end
  end

  assign bus.out        = lane_q;
  assign bus.serial_out = serial_out_q;
  assign bus.step       = step_q;
  assign bus.hit_ok     = hit_ok_q;
  assign bus.miss       = miss_q;

endmodule

// File: tb/tb_note_lane_shifter.sv
// tb/tb_note_lane_shifter.sv - randomized and directed bench for note_lane_shifter against a lane model
module tb_note_lane_shifter;
  localparam int W  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_n = 1'b1;
  logic [W-1:0]  load_val = '0;
  logic          serial_in = 1'b0;
  logic          shift_en = 1'b0;
  logic          dir = 1'b0;
  logic [DW-1:0] rate = '0;
  logic          hit = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  int hit_pos [2] = '{1, 0};
  int m_lane  [2];
  int m_div   [2];
  int m_sout  [2];
  int m_step  [2];
  int m_hok   [2];
  int m_miss  [2];

  always #5 clk = ~clk;

  note_lane_shifter_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus0 ();
  note_lane_shifter_if #(.WIDTH(W), .DIV_WIDTH(DW)) bus1 ();

  assign bus0.load_n = load_n;    assign bus1.load_n = load_n;
  assign bus0.load_val = load_val; assign bus1.load_val = load_val;
  assign bus0.serial_in = serial_in; assign bus1.serial_in = serial_in;
  assign bus0.shift_en = shift_en; assign bus1.shift_en = shift_en;
  assign bus0.dir = dir;          assign bus1.dir = dir;
  assign bus0.rate = rate;        assign bus1.rate = rate;
  assign bus0.hit = hit;          assign bus1.hit = hit;

  note_lane_shifter #(.WIDTH(W), .DIV_WIDTH(DW), .HIT_POS(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  note_lane_shifter #(.WIDTH(W), .DIV_WIDTH(DW), .HIT_POS(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lane[i] = 0; m_div[i] = 0; m_sout[i] = 0;
      m_step[i] = 0; m_hok[i] = 0; m_miss[i] = 0;
    end
  endtask

  // Lane as an integer: a dir=0 step divides by two and adds the entry at the top.
  task automatic model_edge();
    int v, e, term;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        model_reset();
      end else if (!load_n) begin
        m_lane[i] = int'(load_val); m_div[i] = 0;
        m_step[i] = 0; m_hok[i] = 0; m_miss[i] = 0;
      end else begin
        m_hok[i] = (hit && ((m_lane[i] >> hit_pos[i]) % 2 == 1)) ? 1 : 0;
        v = m_lane[i];
        if (hit && m_hok[i] == 1) v = v - (1 << hit_pos[i]);
        term = (shift_en && m_div[i] >= int'(rate)) ? 1 : 0;
        if (shift_en) m_div[i] = term ? 0 : m_div[i] + 1;
        if (term) begin
          if (!dir) begin
            e = v % 2;
            v = v / 2 + (serial_in ? (1 << (W - 1)) : 0);
          end else begin
            e = v / (1 << (W - 1));
            v = (v * 2) % (1 << W) + (serial_in ? 1 : 0);
          end
          m_sout[i] = e; m_miss[i] = e; m_step[i] = 1;
        end else begin
          m_step[i] = 0; m_miss[i] = 0;
        end
        m_lane[i] = v;
      end
    end
  endtask

  task automatic check_inst(input int i, input logic [W-1:0] o, input logic so,
                            input logic st, input logic hk, input logic ms);
    check($sformatf("out%0d", i),  32'(o),  32'(m_lane[i]));
    check($sformatf("sout%0d", i), 32'(so), 32'(m_sout[i]));
    check($sformatf("step%0d", i), 32'(st), 32'(m_step[i]));
    check($sformatf("hok%0d", i),  32'(hk), 32'(m_hok[i]));
    check($sformatf("miss%0d", i), 32'(ms), 32'(m_miss[i]));
  endtask

  task automatic check_all();
    check_inst(0, bus0.out, bus0.serial_out, bus0.step, bus0.hit_ok, bus0.miss);
    check_inst(1, bus1.out, bus1.serial_out, bus1.step, bus1.hit_ok, bus1.miss);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_load(input logic [W-1:0] val);
    load_n = 1'b0; load_val = val;
    tick();
    load_n = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk); #1 rst = 1'b0;

    // reset mid-count acts immediately
    rate = 8'd5; shift_en = 1'b1;
    do_load(8'hA5);
    ticks(2);
    #2 rst = 1'b1;
    #1 model_reset();
    check("rst_async_out", 32'(bus0.out), 32'h0);
    check_all();
    ticks(2);
    rst = 1'b0;

    // step basics
    rate = 8'd2; dir = 1'b0; serial_in = 1'b0; shift_en = 1'b1;
    do_load(8'h81);
    ticks(2);
    check("pre_step", 32'(bus0.step), 32'h0);
    tick();
    check("b_out1", 32'(bus0.out), 32'h40);
    check("b_step1", 32'(bus0.step), 32'h1);
    check("b_miss1", 32'(bus0.miss), 32'h1);
    check("b_sout1", 32'(bus0.serial_out), 32'h1);
    ticks(3);
    check("b_out2", 32'(bus0.out), 32'h20);
    check("b_miss2", 32'(bus0.miss), 32'h0);

    // direction
    dir = 1'b1; serial_in = 1'b1; rate = 8'd0;
    do_load(8'h81);
    tick();
    check("d_out1", 32'(bus0.out), 32'h03);
    check("d_miss1", 32'(bus0.miss), 32'h1);
    tick();
    check("d_out2", 32'(bus0.out), 32'h07);
    check("d_miss2", 32'(bus0.miss), 32'h0);

    // hit window
    dir = 1'b0; serial_in = 1'b0; shift_en = 1'b0;
    do_load(8'h02);
    hit = 1'b1;
    tick();
    check("h_ok1", 32'(bus0.hit_ok), 32'h1);
    check("h_out1", 32'(bus0.out), 32'h00);
    tick();
    hit = 1'b0;
    check("h_ok2", 32'(bus0.hit_ok), 32'h0);
    check("h_out2", 32'(bus0.out), 32'h00);

    // hit versus exit on the HIT_POS=0 lane
    rate = 8'd0;
    do_load(8'h01);
    shift_en = 1'b1; hit = 1'b1;
    tick();
    hit = 1'b0; shift_en = 1'b0;
    check("x_ok", 32'(bus1.hit_ok), 32'h1);
    check("x_miss", 32'(bus1.miss), 32'h0);
    check("x_step", 32'(bus1.step), 32'h1);
    check("x_out", 32'(bus1.out), 32'h00);
    check("x_sout", 32'(bus1.serial_out), 32'h0);

    // load priority over hit and terminal count, then pause/resume
    hit = 1'b1; shift_en = 1'b1; rate = 8'd0;
    do_load(8'hFF);
    hit = 1'b0;
    check("p_out", 32'(bus0.out), 32'hFF);
    check("p_step", 32'(bus0.step), 32'h0);
    check("p_hok", 32'(bus0.hit_ok), 32'h0);
    check("p_miss", 32'(bus0.miss), 32'h0);
    rate = 8'd3;
    tick();
    shift_en = 1'b0;
    ticks(10);
    shift_en = 1'b1;
    ticks(2);
    check("r_step_early", 32'(bus0.step), 32'h0);
    tick();
    check("r_step", 32'(bus0.step), 32'h1);
    check("r_out", 32'(bus0.out), 32'h7F);

    // lowering rate mid-count
    shift_en = 1'b0;
    do_load(8'h10);
    rate = 8'd10; shift_en = 1'b1;
    ticks(6);
    rate = 8'd2;
    tick();
    check("c_step1", 32'(bus0.step), 32'h1);
    ticks(2);
    check("c_gap", 32'(bus0.step), 32'h0);
    tick();
    check("c_step2", 32'(bus0.step), 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      load_n    = ($urandom_range(0, 15) != 0);
      load_val  = W'($urandom);
      serial_in = $urandom_range(0, 1) == 1;
      shift_en  = ($urandom_range(0, 3) != 0);
      hit       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) rate = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/note_lane_shifter.md
# note_lane_shifter

Parametrised lane shift register for note scrolling. It generalises the fixed 5-bit load/shift register to WIDTH bits and adds several features:
- a built-in rate divider, so shifting runs autonomously at a programmable step interval;
- selectable shift direction;
- hit detection at a configurable tap position;
- miss detection on notes leaving the lane.

It sits between the chart/note sequencer, which loads or serially feeds notes, and the display and scoring logic, which read the lane and the hit/miss pulses.

## Interface
- WIDTH, 16, lane length in bits (≥ 2)
- DIV_WIDTH, 8, width of the step-rate divider
- HIT_POS, 1, bit index of the hit window (0 ≤ HIT_POS < WIDTH)
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- load_n  in  1  active-low parallel load
- load_val  in  WIDTH  parallel load value
- serial_in  in  1  bit entering the lane on each step
- shift_en  in  1  enables the divider and stepping
- dir  in  1  0: shift toward bit 0 (entry at WIDTH-1); 1: toward WIDTH-1 (entry at bit 0)
- rate  in  DIV_WIDTH  step every rate+1 enabled cycles
- hit  in  1  player hit strobe, one cycle
- out  out  WIDTH  lane contents
- serial_out  out  1  last bit shifted out
- step  out  1  pulse: lane shifted on the preceding edge
- hit_ok  out  1  pulse: hit found a note at HIT_POS
- miss  out  1  pulse: a note (1) left the lane

## Operation
- State:
  - out register;
  - div_cnt[DIV_WIDTH-1:0];
  - registered pulse outputs step, hit_ok, miss;
  - serial_out register.
- Per-edge priority: reset > load > (hit clear, then step).
- Load (load_n=0):
  - out ← load_val; div_cnt ← 0.
  - step, hit_ok and miss ← 0; serial_out holds.
  - hit and shift_en are ignored that cycle.
- Terminal count: term = shift_en & (div_cnt ≥ rate).
  - Using ≥ ensures that lowering rate mid-count fires the step on the next enabled cycle.
- Divider:
  - shift_en=1: if term, div_cnt ← 0; else div_cnt ← div_cnt+1.
  - shift_en=0: div_cnt holds.
- Hit evaluation (load_n=1):
  - hit_ok ← hit & out[HIT_POS], evaluated on the pre-edge value.
  - If hit=1, bit HIT_POS is treated as 0 for the rest of this edge, giving the value v.
  - A hit on an empty slot does not change the lane and gives no pulse.
- Step (load_n=1, term=1), applied to v:
  - dir=0: out ← {serial_in, v[WIDTH-1:1]}, exiting bit e = v[0].
  - dir=1: out ← {v[WIDTH-2:0], serial_in}, exiting bit e = v[WIDTH-1].
  - serial_out ← e; miss ← e; step ← 1.
  - A note hit on the same edge it would exit does not produce a miss.
- No step: out ← v; step ← 0; miss ← 0; serial_out holds.
- A dir change takes effect on the next step. No state depends on the previous direction.
- rate=0 with shift_en held high steps on every cycle.

## Timing
- Reset values: out=0, div_cnt=0, serial_out=0, step=0, hit_ok=0, miss=0.
- Reset acts immediately on assertion, including mid-count or mid-load, and holds while asserted.
- After reset deasserts, the first step needs rate+1 enabled edges.
- Step interval: the first step comes on the (rate+1)-th enabled rising edge after load, reset or enable from div_cnt=0.
  - Steps repeat every rate+1 enabled edges after that.
  - Deasserting shift_en pauses the count; reasserting resumes from the held div_cnt.
- Output timing:
  - out and serial_out change on the step edge.
  - step, miss and hit_ok are high for exactly one cycle after the edge that caused them.
- hit latency: hit_ok is high the cycle after the strobe, and out[HIT_POS] is cleared on the same edge.
  - hit held for multiple cycles is evaluated on each edge. Only the first can succeed unless a new note has arrived at HIT_POS.
- Load latency: one edge. out equals load_val in the following cycle.

## Test plan
- Reset and step basics (WIDTH=8, HIT_POS=1): assert reset mid-count → all outputs 0 immediately. Then load 8'h81, rate=2, dir=0, serial_in=0, shift_en=1 → after 3 edges out=8'h40, step=1, miss=1, serial_out=1. After 3 more edges out=8'h20, miss=0.
- Direction: load 8'h81, dir=1, serial_in=1, rate=0 → after 1 edge out=8'h03, miss=1. After 1 more edge out=8'h07, miss=0.
- Hit window: load 8'h02, shift_en=0, hit=1 for one cycle → hit_ok=1, out=8'h00. Repeat hit → hit_ok=0, out unchanged.
- Hit versus exit: HIT_POS=0, load 8'h01, rate=0, shift_en=1, hit=1 on the first edge → hit_ok=1, miss=0, step=1, out=8'h00, serial_out=0.
- Priority and pause: hit, load_n=0 (load_val=8'hFF) and a terminal-count edge together → out=8'hFF, step=hit_ok=miss=0, div_cnt=0. Drop shift_en after 1 edge with rate=3, wait 10 edges, re-enable → step after 3 more edges.
- Rate change: rate=10, shift_en=1 for 6 edges, then rate=2 → step on the next edge, then every 3 edges.
